pattern_tx: RTL and testbench



---
 rtl/pattern_tx.sv | 160 ++++++++++++++++
 tb/tb_pattern_tx.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pattern_tx.sv
// pattern_tx: parallel-to-serial pattern transmitter. A captured pattern is
// shifted out MSB-first for a programmed number of frames, with optional idle
// gaps between frames. All outputs are registered.
module pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  input  logic [LEN_W-1:0] gap,
  input  logic             stop,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             frame_end,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] gcnt_q, gcnt_d;
  logic [REP_W-1:0] cnt_q, cnt_d;
  logic             stop_q, stop_d;
  logic             stop_eff;

  // Shadow copies of the run parameters, frozen at start.
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [LEN_W-1:0] gap_q, gap_d;

  logic out_q, out_d;
  logic valid_q, valid_d;
  logic busy_q, busy_d;
  logic frame_end_q, frame_end_d;
  logic done_q, done_d;
  logic [WIDTH-1:0] shifted;

  // A zero or oversized length means "use the full pattern width".
  function automatic logic [LEN_W-1:0] len_eff(input logic [LEN_W-1:0] l);
    if (l == '0 || l > LEN_W'(WIDTH)) return LEN_W'(WIDTH);
    return l;
  endfunction

  // Next-state logic; registered outputs are derived from the next state.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gcnt_d      = gcnt_q;
    cnt_d       = cnt_q;
    stop_d      = stop_q;
    pat_d       = pat_q;
    len_d       = len_q;
    reps_d      = reps_q;
    gap_d       = gap_q;
    stop_eff    = stop_q | stop;
    case (state_q)
      S_IDLE: begin
        // Stop is never latched in IDLE, even alongside start.
        stop_d = 1'b0;
        if (start) begin
          pat_d   = pattern;
          len_d   = len_eff(len);
          reps_d  = reps;
          gap_d   = gap;
          cnt_d   = '0;
          idx_d   = len_d - LEN_W'(1);
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        stop_d = stop_eff;
        if (idx_q != '0) begin
          idx_d = idx_q - LEN_W'(1);
        end else begin
          // Frame boundary: count it, then pick done / gap / next frame.
          cnt_d = cnt_q + REP_W'(1);
          if (stop_eff || (reps_q != '0 && cnt_d == reps_q)) begin
            state_d = S_DONE;
          end else if (gap_q != '0) begin
            state_d = S_GAP;
            gcnt_d  = gap_q;
          end else begin
            idx_d = len_q - LEN_W'(1);
          end
        end
      end
      S_GAP: begin
        stop_d = stop_eff;
        if (stop_eff) begin
          state_d = S_DONE;
        end else if (gcnt_q == LEN_W'(1)) begin
          state_d = S_SEND;
          idx_d   = len_q - LEN_W'(1);
        end else begin
          gcnt_d = gcnt_q - LEN_W'(1);
        end
      end
      default: begin
        stop_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    shifted     = pat_d >> idx_d;
    out_d       = (state_d == S_SEND) & shifted[0];
    valid_d     = (state_d == S_SEND);
    busy_d      = (state_d == S_SEND) || (state_d == S_GAP);
    frame_end_d = (state_d == S_SEND) && (idx_d == '0);
    done_d      = (state_d == S_DONE);
  end

  // Control state and registered outputs, with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      gcnt_q      <= '0;
      cnt_q       <= '0;
      stop_q      <= 1'b0;
      out_q       <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_end_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gcnt_q      <= gcnt_d;
      cnt_q       <= cnt_d;
      stop_q      <= stop_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_end_q <= frame_end_d;
      done_q      <= done_d;
    end
  end

  // Shadow registers hold data only and need no reset.
  always_ff @(posedge clock) begin
    pat_q  <= pat_d;
    len_q  <= len_d;
    reps_q <= reps_d;
    gap_q  <= gap_d;
  end

  assign out       = out_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign frame_end = frame_end_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: directed and randomized runs compared per cycle with
// an arithmetic model of the serial stream (frame/gap positions per cycle).
module tb_pattern_tx;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;
  logic [3:0] gap = '0;
  logic       stop = 1'b0;
  logic       out, valid, busy, frame_end, done;

  int n_tests = 0;
  int n_fail  = 0;

  pattern_tx #(.WIDTH(8), .LEN_W(4), .REP_W(4)) dut (
    .clock(clock), .reset(reset), .start(start), .pattern(pattern),
    .len(len), .reps(reps), .gap(gap), .stop(stop),
    .out(out), .valid(valid), .busy(busy), .frame_end(frame_end), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got[4:0], exp[4:0]);
    end
  endtask

  function automatic logic [4:0] obs();
    return {out, valid, busy, frame_end, done};
  endfunction

  // One run: s is the run-relative cycle in which stop is held (-1 = never).
  // Expected stream: cycle t of the run is in frame t/P at position t%P,
  // where P = L + G; positions below L carry pattern bit L-1-pos.
  task automatic run(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                     input logic [3:0] g, input int s, input bit noise);
    int L, G, P, R, bnom, B, nfr, pos;
    logic [4:0] exp;
    logic [7:0] pv;
    pv = p;
    L = (l == 0 || l > 8) ? 8 : int'(l);
    G = int'(g);
    P = L + G;
    R = int'(r);
    bnom = (R == 0) ? 32'h7fffffff : R * L + (R - 1) * G;
    if (s >= 0 && s < bnom) begin
      if ((s % P) < L) begin
        nfr = s / P + 1;
        B = nfr * L + (nfr - 1) * G;
      end else begin
        B = s + 1;
      end
    end else begin
      B = bnom;
    end
    @(negedge clock);
    pattern = p; len = l; reps = r; gap = g; start = 1'b1;
    stop = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int t = 0; t <= B + 1; t++) begin
      @(negedge clock);
      if (t < B) begin
        pos = t % P;
        exp[4] = (pos < L) ? pv[L - 1 - pos] : 1'b0;
        exp[3] = (pos < L);
        exp[2] = 1'b1;
        exp[1] = (pos == L - 1);
        exp[0] = 1'b0;
      end else if (t == B) begin
        exp = 5'b00001;
      end else begin
        exp = 5'b00000;
      end
      check_eq($sformatf("run p=%h l=%0d r=%0d g=%0d t=%0d", p, l, r, g, t), 32'(obs()), 32'(exp));
      stop = (t == s);
      start = (noise && t <= B) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        pattern = 8'($urandom); len = 4'($urandom); reps = 4'($urandom); gap = 4'($urandom);
      end
    end
    start = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check_eq("reset_hold", 32'(obs()), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("reset_idle", 32'(obs()), 32'd0);

    // stop alone in IDLE is ignored
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    check_eq("stop_in_idle", 32'(obs()), 32'd0);

    // Directed cases
    run(8'hA5, 4'd8, 4'd1, 4'd0, -1, 1'b0);
    run(8'h0A, 4'd4, 4'd3, 4'd2, -1, 1'b0);
    run(8'h06, 4'd3, 4'd0, 4'd0, 4, 1'b0);
    run(8'h81, 4'd0, 4'd1, 4'd0, -1, 1'b1);
    run(8'h0A, 4'd4, 4'd2, 4'd0, -1, 1'b0);
    run(8'h3C, 4'd12, 4'd2, 4'd1, -1, 1'b0);
    run(8'h01, 4'd1, 4'd3, 4'd0, -1, 1'b0);
    run(8'h05, 4'd3, 4'd0, 4'd3, 7, 1'b0);

    // Reset on the 3rd bit of an 8-bit frame
    @(negedge clock);
    pattern = 8'hC3; len = 4'd8; reps = 4'd1; gap = 4'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_eq("rst_bit1", 32'(obs()), 32'(5'b11100));
    @(negedge clock);
    check_eq("rst_bit2", 32'(obs()), 32'(5'b11100));
    @(negedge clock);
    check_eq("rst_bit3", 32'(obs()), 32'(5'b01100));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_eq("rst_mid_run", 32'(obs()), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_eq("rst_no_done", 32'(obs()), 32'd0);
    end
    run(8'h96, 4'd8, 4'd1, 4'd0, -1, 1'b0);

    // Randomized runs
    for (int k = 0; k < 40; k++) begin
      logic [7:0] rp;
      logic [3:0] rl, rr, rg;
      int le, pp, bn, rs;
      rp = 8'($urandom);
      rl = 4'($urandom);
      rr = 4'($urandom_range(0, 4));
      rg = 4'($urandom_range(0, 3));
      le = (rl == 0 || rl > 8) ? 8 : int'(rl);
      pp = le + int'(rg);
      if (rr == 0) begin
        rs = $urandom_range(0, 3 * pp - 1);
      end else begin
        bn = int'(rr) * le + (int'(rr) - 1) * int'(rg);
        rs = ($urandom_range(0, 1) == 1) ? -1 : $urandom_range(0, bn + 1);
      end
      run(rp, rl, rr, rg, rs, 1'(k % 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
